config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001: Parameter CHAIN_LENGTH, default 24, total bits in the target configuration shift chain; legal range is 1 or more.
REQ-002: Parameter WORD_WIDTH, default 8, width of each bitstream word accepted from the host; legal range is 1 or more.
REQ-003: config_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004: config_nreset  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006: abort  input  1  terminate any load in progress.
REQ-007: word_data  input  WORD_WIDTH  bitstream word from the host.
REQ-008: word_valid  input  1  word_data holds a valid word.
REQ-009: word_ready  output  1  loader accepts word_data this cycle.
REQ-010: config_out  output  1  serial bit, wired to the chain head's config_in.
REQ-011: config_enable  output  1  chain shift enable; shared by all tiles.
REQ-012: busy  output  1  high in LOAD or SHIFT.
REQ-013: done  output  1  high in DONE.

Function
REQ-014: The loader SHALL use four states: IDLE, LOAD, SHIFT and DONE.
REQ-015: IDLE or DONE with start=1 SHALL go to LOAD and clear the bit counter to 0.
REQ-016: In LOAD, word_ready SHALL be 1 and no other state SHALL drive it high.
REQ-017: A word SHALL be accepted when word_valid and word_ready are both 1; acceptance latches word_data into a shift buffer and moves the state to SHIFT.
REQ-018: In SHIFT, the loader SHALL register config_enable=1 and config_out=buffer[0] each cycle, shift the buffer right by one, and increment the bit counter; words are sent LSB first.
REQ-019: Bits shifted from one word SHALL equal min(WORD_WIDTH, CHAIN_LENGTH - bits already shifted); any unused high bits of the final word are discarded.
REQ-020: After the word's last bit, the state SHALL go to DONE if the counter equals CHAIN_LENGTH, and to LOAD otherwise.
REQ-021: config_enable SHALL be 0 in every state other than SHIFT; config_out SHALL hold its last value when config_enable is 0.
REQ-022: A full-width word SHALL take WORD_WIDTH+1 cycles with no backpressure: one LOAD cycle plus WORD_WIDTH SHIFT cycles.
REQ-023: word_valid=0 in LOAD SHALL stall the load with no shifting and no timeout.
REQ-024: start while busy=1 SHALL be ignored.
REQ-025: abort=1 in LOAD or SHIFT SHALL force IDLE on the next edge, with config_enable=0 that same edge and any partially shifted word dropped.
REQ-026: abort SHALL take priority over start and over word acceptance in the same cycle; abort in IDLE or DONE SHALL go to IDLE.
REQ-027: The bit counter SHALL be $clog2(CHAIN_LENGTH+1) bits wide and SHALL never exceed CHAIN_LENGTH.
REQ-028: done SHALL stay 1 until the next start or abort.

Reset
REQ-029: config_nreset=0 SHALL immediately force IDLE and counter=0, with config_enable, config_out, word_ready, busy and done all 0.
REQ-030: Reset mid-SHIFT SHALL drop config_enable within the same cycle, without waiting for a clock edge.
REQ-031: Deassertion SHALL resume in IDLE with no chain activity until start.

Configuration
REQ-032: Macro CONFIG_LOADER_CHECKSUM_EN, when defined, SHALL add output checksum (WORD_WIDTH bits), the XOR of all words accepted since the last start.
REQ-033: checksum SHALL be cleared by start, abort and reset, and SHALL be updated on the edge that accepts a word.
REQ-034: Without the macro, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035: CHAIN_LENGTH=24, WORD_WIDTH=8, words 0xA5, 0x3C, 0xFF with valid held high -> config_enable high for three 8-cycle bursts separated by one-cycle gaps; config_out sequence 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / 1 x8; done=1 after 27 cycles; checksum=0x66 when enabled.
REQ-036: CHAIN_LENGTH=20, words 0x00, 0x00, 0xF7 -> the last burst is exactly 4 cycles of config_out=1,1,1,0; total enable-high cycles is 20.
REQ-037: word_valid=0 for 5 cycles in LOAD between words -> config_enable low and counter frozen for those 5 cycles; the bit stream is otherwise unchanged.
REQ-038: abort asserted on the 3rd SHIFT cycle of word 2 -> IDLE on the next edge, config_enable=0, done=0; start then reloads from bit 0.
REQ-039: config_nreset pulsed low mid-SHIFT between clock edges -> outputs go to 0 asynchronously; start=1 while busy -> no effect.

Source files
------------

// File: rtl/config_loader.sv
// Streams host bitstream words LSB-first into a serial configuration shift chain.
// Optional feature macro CONFIG_LOADER_CHECKSUM_EN adds 'checksum': XOR of words accepted since the last start.
module config_loader #(
  parameter int CHAIN_LENGTH = 24,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done
`ifdef CONFIG_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] WORD_LAST  = IDX_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [IDX_W-1:0]      wordIdx_q, wordIdx_d;
  logic [WORD_WIDTH-1:0] shiftBuf_q, shiftBuf_d;
  logic                  cfgOut_q, cfgOut_d;
  logic                  cfgEn_q, cfgEn_d;
  logic                  lastBit;
  logic                  idleOrDone;

  // A word ends at its top bit or when the chain is full, whichever is first.
  assign lastBit    = (wordIdx_q == WORD_LAST) || (bitCnt_q == CHAIN_LAST);
  assign idleOrDone = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    wordIdx_d  = wordIdx_q;
    shiftBuf_d = shiftBuf_q;
    cfgOut_d   = cfgOut_q;
    cfgEn_d    = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = LOAD;
            bitCnt_d = '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            state_d    = SHIFT;
            cfgOut_d   = word_data[0];
            shiftBuf_d = word_data >> 1;
            wordIdx_d  = '0;
            cfgEn_d    = 1'b1;
          end
        end
        SHIFT: begin
          bitCnt_d = bitCnt_q + 1'b1;
          if (lastBit) begin
            state_d = (bitCnt_q == CHAIN_LAST) ? DONE : LOAD;
          end else begin
            cfgOut_d   = shiftBuf_q[0];
            shiftBuf_d = shiftBuf_q >> 1;
            wordIdx_d  = wordIdx_q + 1'b1;
            cfgEn_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      wordIdx_q  <= '0;
      shiftBuf_q <= '0;
      cfgOut_q   <= 1'b0;
      cfgEn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      wordIdx_q  <= wordIdx_d;
      shiftBuf_q <= shiftBuf_d;
      cfgOut_q   <= cfgOut_d;
      cfgEn_q    <= cfgEn_d;
    end
  end

  assign word_ready    = (state_q == LOAD);
  assign busy          = (state_q == LOAD) || (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign config_out    = cfgOut_q;
  assign config_enable = cfgEn_q;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (abort || (start && idleOrDone)) begin
      chk_d = '0;
    end else if ((state_q == LOAD) && word_valid) begin
      chk_d = chk_q ^ word_data;
    end
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`else
  // Without the checksum, a start from IDLE/DONE needs no extra bookkeeping.
  logic unusedIdleOrDone;
  assign unusedIdleOrDone = idleOrDone;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Drives two config_loader instances (24-bit and 20-bit chains) with shared random stimulus
// and checks bitstream, burst shape, timing and status against a word-level reference model.
module tb_config_loader;

  localparam int WW = 8;

  logic          config_clock = 1'b0;
  logic          config_nreset;
  logic          start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic          rdy  [0:1];
  logic          outb [0:1];
  logic          en   [0:1];
  logic          bsy  [0:1];
  logic          dn   [0:1];
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WW-1:0] chk  [0:1];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic streamBits [0:1][0:4095];
  int   nBits   [0:1];
  int   nRuns   [0:1];
  int   curRun  [0:1];
  int   runLen  [0:1][0:511];
  int   doneCyc [0:1];
  bit   prevDone[0:1];

  always #5 config_clock = ~config_clock;

  config_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(WW)) u24 (
    .config_clock(config_clock), .config_nreset(config_nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[0]), .config_out(outb[0]),
    .config_enable(en[0]), .busy(bsy[0]), .done(dn[0])
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , .checksum(chk[0])
`endif
  );

  config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(WW)) u20 (
    .config_clock(config_clock), .config_nreset(config_nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[1]), .config_out(outb[1]),
    .config_enable(en[1]), .busy(bsy[1]), .done(dn[1])
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , .checksum(chk[1])
`endif
  );

  always @(posedge config_clock) cyc <= cyc + 1;

  // Chain-side monitor: records every enabled bit, burst lengths and the cycle done rises.
  always @(negedge config_clock) begin
    for (int d = 0; d < 2; d++) begin
      prevDone[d] <= dn[d];
      if (dn[d] && !prevDone[d]) doneCyc[d] <= cyc;
      if (en[d]) begin
        streamBits[d][nBits[d]] <= outb[d];
        nBits[d]  <= nBits[d] + 1;
        curRun[d] <= curRun[d] + 1;
      end else if (curRun[d] != 0) begin
        runLen[d][nRuns[d]] <= curRun[d];
        nRuns[d]  <= nRuns[d] + 1;
        curRun[d] <= 0;
      end
    end
  end

  function automatic int chainLen(input int d);
    return (d == 0) ? 24 : 20;
  endfunction

  function automatic int wordBits(input int len, input int i);
    int rem;
    rem = len - WW * i;
    return (rem < WW) ? rem : WW;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge config_clock);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic checkQuiet(input string tag, input logic expDone);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_en_d%0d", tag, d), en[d], 1'b0);
      checkOutput($sformatf("%s_busy_d%0d", tag, d), bsy[d], 1'b0);
      checkOutput($sformatf("%s_ready_d%0d", tag, d), rdy[d], 1'b0);
      checkOutput($sformatf("%s_done_d%0d", tag, d), dn[d], expDone);
    end
  endtask

  // Offers one word: 'stall' LOAD cycles with valid low first; with noise, junk valid
  // and start pulses are driven while the loader is busy shifting.
  task automatic sendWord(input logic [WW-1:0] d, input int stall, input bit noise);
    int g = 0;
    int guard = 0;
    bit acc = 1'b0;
    while (!acc && guard < 100) begin
      if (rdy[0]) begin
        word_valid = (g >= stall);
        if (g < stall) g++;
      end else begin
        word_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      word_data = word_valid ? d : WW'($urandom);
      if (rdy[0]) word_data = (g >= stall) ? d : WW'($urandom);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = rdy[0] && word_valid;
      tick();
      guard++;
    end
    checkOutput("accept_wait", acc, 1'b1);
    word_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                               input logic [WW-1:0] w2, input int s0, input int s1,
                               input int s2, input bit noise);
    logic [WW-1:0] w [0:2];
    int st [0:2];
    int n0 [0:1];
    int r0 [0:1];
    int startCyc, guard, len, expCycles;
    logic [31:0] expS, gotS;
    w = '{w0, w1, w2};
    st = '{s0, s1, s2};
    for (int d = 0; d < 2; d++) begin
      n0[d] = nBits[d];
      r0[d] = nRuns[d];
    end
    doStart();
    startCyc = cyc;
    for (int i = 0; i < 3; i++) sendWord(w[i], st[i], noise);
    guard = 0;
    while (!(dn[0] && dn[1]) && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("done_wait", dn[0] && dn[1], 1'b1);
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      len = chainLen(d);
      expS = '0;
      gotS = '0;
      expCycles = 0;
      for (int k = 0; k < len; k++) begin
        expS[k] = w[k / WW][k % WW];
        gotS[k] = streamBits[d][n0[d] + k];
      end
      for (int i = 0; i < 3; i++) expCycles += st[i] + 1 + wordBits(len, i);
      checkOutput($sformatf("bitcount_d%0d", d), nBits[d] - n0[d], len);
      checkOutput($sformatf("stream_d%0d", d), gotS, expS);
      checkOutput($sformatf("done_cycles_d%0d", d), doneCyc[d] - startCyc, expCycles);
      checkOutput($sformatf("bursts_d%0d", d), nRuns[d] - r0[d], 3);
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("burst%0d_len_d%0d", i, d), runLen[d][r0[d] + i], wordBits(len, i));
      checkOutput($sformatf("out_hold_d%0d", d), outb[d], expS[len - 1]);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checkOutput($sformatf("checksum_d%0d", d), chk[d], w0 ^ w1 ^ w2);
`endif
    end
    checkQuiet("after_load", 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nSnap [0:1];
    config_nreset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_out_d%0d", d), outb[d], 1'b0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checkOutput($sformatf("rst_checksum_d%0d", d), chk[d], '0);
`endif
    end
    checkQuiet("rst", 1'b0);
    #9 config_nreset = 1'b1;
    @(posedge config_clock);
    #1;
    repeat (3) tick();
    checkQuiet("post_reset", 1'b0);

    $display("[TB] directed loads");
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 0, 0, 0, 1'b0);
    repeat (4) tick();
    checkQuiet("done_hold", 1'b1);
    applyStimulus(8'h00, 8'h00, 8'hF7, 0, 0, 0, 1'b0);
    applyStimulus(WW'($urandom), WW'($urandom), WW'($urandom), 0, 5, 0, 1'b0);

    $display("[TB] random loads with stalls and busy-time start pulses");
    for (int i = 0; i < 6; i++)
      applyStimulus(WW'($urandom), WW'($urandom), WW'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkQuiet("abort_in_done", 1'b0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkQuiet("abort_beats_start", 1'b0);

    $display("[TB] abort against word acceptance");
    for (int d = 0; d < 2; d++) nSnap[d] = nBits[d];
    doStart();
    word_data = WW'($urandom);
    word_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    word_valid = 1'b0;
    checkQuiet("abort_beats_accept", 1'b0);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("abort_accept_bits_d%0d", d), nBits[d] - nSnap[d], 0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checkOutput($sformatf("abort_accept_checksum_d%0d", d), chk[d], '0);
`endif
    end

    $display("[TB] abort on third shift cycle of word 2");
    for (int d = 0; d < 2; d++) nSnap[d] = nBits[d];
    doStart();
    sendWord(WW'($urandom), 0, 1'b0);
    sendWord(WW'($urandom), 0, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkQuiet("abort_shift", 1'b0);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("abort_shift_bits_d%0d", d), nBits[d] - nSnap[d], 11);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checkOutput($sformatf("abort_shift_checksum_d%0d", d), chk[d], '0);
`endif
    end
    applyStimulus(WW'($urandom), WW'($urandom), WW'($urandom), 1, 0, 2, 1'b1);

    $display("[TB] asynchronous reset mid-shift");
    doStart();
    sendWord(8'hFF, 0, 1'b0);
    tick();
    #2 config_nreset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("async_rst_out_d%0d", d), outb[d], 1'b0);
    checkQuiet("async_rst", 1'b0);
    #2 config_nreset = 1'b1;
    @(posedge config_clock);
    #1;
    for (int d = 0; d < 2; d++) nSnap[d] = nBits[d];
    repeat (4) tick();
    checkQuiet("after_async_rst", 1'b0);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("after_rst_bits_d%0d", d), nBits[d] - nSnap[d], 0);
    applyStimulus(WW'($urandom), WW'($urandom), WW'($urandom), 0, 2, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
